// File: rtl/freq_synth_cal_master.sv
// freq_synth_cal_master: autonomous fine-code calibration initiator for the
// frequency-synth register bus. It enables the ring oscillator, binary-searches
// a thermometer fine code by measuring the counter delta over a window, then
// writes back the smallest code whose delta meets the target.
module freq_synth_cal_master #(
    parameter int          WIN_W      = 16,
    parameter int          TIMEOUT    = 15,
    parameter logic [5:0]  ADDR_FINE  = 6'h04,
    parameter logic [5:0]  ADDR_CTRL  = 6'h10,
    parameter logic [5:0]  ADDR_COUNT = 6'h20,
    parameter logic [31:0] CTRL_VALUE = 32'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      target_count,
    input  logic [WIN_W-1:0] window_cycles,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             error,
    output logic [5:0]       result_code,
    output logic [5:0]       bus_address,
    output logic [31:0]      bus_wdata,
    output logic [1:0]       bus_write_n,
    output logic [1:0]       bus_read_n,
    input  logic [31:0]      bus_rdata,
    input  logic             bus_data_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_EN_WR, S_TRY, S_RD0, S_WAIT, S_RD1, S_EVAL, S_FIN, S_DONE, S_ERR
    } state_t;

    state_t           state;
    logic [31:0]      target_q;
    logic [31:0]      c0;
    logic [31:0]      c1;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] wcnt;
    logic [5:0]       lo;
    logic [5:0]       hi;
    logic [5:0]       code_att;
    logic [TW-1:0]    tmo;
    logic             req_active;

    logic [6:0]       mid_sum;
    logic [5:0]       mid;
    logic [5:0]       fin_code;
    logic [31:0]      meas;
    logic             pass;
    logic [5:0]       lo_next;
    logic [5:0]       hi_next;
    logic [5:0]       req_addr;
    logic [31:0]      req_wdata;
    logic             req_wr;

    function automatic logic [31:0] thermo(input logic [5:0] k);
        logic [31:0] t;
        t = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < 32'(k)) t[i] = 1'b1;
        end
        return t;
    endfunction

    // Search arithmetic: trial midpoint, final code clamp and the wrap-safe delta compare.
    always_comb begin
        mid_sum  = {1'b0, lo} + {1'b0, hi};
        mid      = mid_sum[6:1];
        fin_code = (lo > 6'd32) ? 6'd32 : lo;
        meas     = c1 - c0;
        pass     = (meas <= target_q);
        lo_next  = pass ? lo : code_att + 6'd1;
        hi_next  = pass ? code_att : hi;
    end

    // Request content for whichever bus state is current.
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_wr    = 1'b0;
        case (state)
            S_EN_WR: begin req_addr = ADDR_CTRL;  req_wdata = CTRL_VALUE;       req_wr = 1'b1; end
            S_TRY:   begin req_addr = ADDR_FINE;  req_wdata = thermo(mid);      req_wr = 1'b1; end
            S_RD0:   begin req_addr = ADDR_COUNT; end
            S_RD1:   begin req_addr = ADDR_COUNT; end
            S_FIN:   begin req_addr = ADDR_FINE;  req_wdata = thermo(fin_code); req_wr = 1'b1; end
            default: begin req_addr = '0; end
        endcase
    end

    // Calibration sequencer with registered bus request and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            locked      <= 1'b0;
            error       <= 1'b0;
            result_code <= '0;
            bus_address <= '0;
            bus_wdata   <= '0;
            bus_write_n <= 2'b11;
            bus_read_n  <= 2'b11;
            target_q    <= '0;
            c0          <= '0;
            c1          <= '0;
            win_q       <= '0;
            wcnt        <= '0;
            lo          <= '0;
            hi          <= '0;
            code_att    <= '0;
            tmo         <= '0;
            req_active  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target_q <= target_count;
                        win_q    <= (window_cycles == '0) ? WIN_W'(1) : window_cycles;
                        lo       <= 6'd0;
                        hi       <= 6'd33;
                        code_att <= 6'd0;
                        busy     <= 1'b1;
                        locked   <= 1'b0;
                        error    <= 1'b0;
                        state    <= S_EN_WR;
                    end
                end
                S_WAIT: begin
                    if (wcnt == win_q - WIN_W'(1)) state <= S_RD1;
                    else                           wcnt  <= wcnt + WIN_W'(1);
                end
                S_EVAL: begin
                    lo    <= lo_next;
                    hi    <= hi_next;
                    state <= (lo_next < hi_next) ? S_TRY : S_FIN;
                end
                S_ERR: begin
                    result_code <= code_att;
                    locked      <= 1'b0;
                    error       <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    // Bus states: issue on entry, hold until ready or timeout; the
                    // completion edge drops the request, giving the idle gap.
                    if (!req_active) begin
                        bus_address <= req_addr;
                        bus_wdata   <= req_wdata;
                        bus_write_n <= req_wr ? 2'b10 : 2'b11;
                        bus_read_n  <= req_wr ? 2'b11 : 2'b10;
                        req_active  <= 1'b1;
                        tmo         <= '0;
                        if (state == S_TRY)      code_att <= mid;
                        else if (state == S_FIN) code_att <= fin_code;
                    end else if (bus_data_ready) begin
                        bus_write_n <= 2'b11;
                        bus_read_n  <= 2'b11;
                        req_active  <= 1'b0;
                        case (state)
                            S_EN_WR: state <= S_TRY;
                            S_TRY:   state <= S_RD0;
                            S_RD0: begin
                                c0    <= bus_rdata;
                                wcnt  <= '0;
                                state <= S_WAIT;
                            end
                            S_RD1: begin
                                c1    <= bus_rdata;
                                state <= S_EVAL;
                            end
                            default: begin
                                result_code <= fin_code;
                                locked      <= (lo <= 6'd32);
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                state       <= S_DONE;
                            end
                        endcase
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        bus_write_n <= 2'b11;
                        bus_read_n  <= 2'b11;
                        req_active  <= 1'b0;
                        state       <= S_ERR;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule
